// File: rtl/button_cmd_pkg.sv
// Shared encodings for the button front end and the LED player FSM,
// plus the play/stop arbitration rule.
package button_cmd_pkg;

  localparam logic [1:0] DB_IDLE   = 2'b00;
  localparam logic [1:0] DB_ARM    = 2'b01;
  localparam logic [1:0] DB_HELD   = 2'b10;
  localparam logic [1:0] DB_DISARM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = DB_IDLE,
    ST_ARM    = DB_ARM,
    ST_HELD   = DB_HELD,
    ST_DISARM = DB_DISARM
  } db_state_t;

  localparam logic [1:0] PLAYER_STOPPED = 2'b00;
  localparam logic [1:0] PLAYER_PLAYING = 2'b01;
  localparam logic [1:0] PLAYER_PAUSED  = 2'b10;

  // Stop always wins; a play press is dropped while stop is pressed or held.
  function automatic logic play_grant(input logic play_evt,
                                      input logic stop_evt,
                                      input logic stop_held);
    return play_evt & ~stop_evt & ~stop_held;
  endfunction

endpackage

// File: rtl/debounce_fsm.sv
// Per-key 2-flop synchronizer and debounce FSM; emits a registered
// one-cycle press event and the debounced pressed level.
module debounce_fsm
  import button_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_evt,
  output logic held
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_t        state;
  db_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             evt_n;

  // Synchronizer stage: idles released so reset never looks like a press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HELD;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      press_evt <= evt_n;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // The entry cycle counts as the first stable sample, so the decision
  // is made when the incremented count reaches the last index.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    evt_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!sync_p1) begin
          state_n = ST_ARM;
          cnt_n   = '0;
        end
      end
      ST_ARM: begin
        if (sync_p1) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_inc == LAST) begin
          state_n = ST_HELD;
          cnt_n   = '0;
          evt_n   = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_HELD: begin
        if (sync_p1) begin
          state_n = ST_DISARM;
          cnt_n   = '0;
        end
      end
      ST_DISARM: begin
        if (!sync_p1) begin
          state_n = ST_HELD;
          cnt_n   = '0;
        end else if (cnt_inc == LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = ST_HELD;
        cnt_n   = '0;
      end
    endcase
  end

  assign held = (state == ST_HELD) || (state == ST_DISARM);

endmodule

// File: rtl/button_cmd.sv
// Play/stop command generator: two debounced keys feeding registered
// arbitration that produces single-cycle play/stop pulses.
module button_cmd
  import button_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_play_n,
  input  logic       key_stop_n,
  output logic       play,
  output logic       stop,
  output logic [1:0] held
);

  logic play_evt;
  logic stop_evt;
  logic play_held;
  logic stop_held;

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_play (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_play_n),
    .press_evt(play_evt),
    .held     (play_held)
  );

  debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_stop (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_stop_n),
    .press_evt(stop_evt),
    .held     (stop_held)
  );

  // Arbitration stage: a suppressed play event is simply lost
  always_ff @(posedge clk) begin
    if (rst) begin
      play <= 1'b0;
      stop <= 1'b0;
    end else begin
      stop <= stop_evt;
      play <= play_grant(play_evt, stop_evt, stop_held);
    end
  end

  assign held = {stop_held, play_held};

endmodule

// File: tb/tb_button_cmd.sv
// Scoreboard bench for button_cmd: a run-length debounce model predicts
// pulses and held levels; a negedge monitor compares them against the DUT.
module tb_button_cmd;

  localparam int DC = 4;
  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_play_n = 1'b1;
  logic       key_stop_n = 1'b1;
  logic       play;
  logic       stop;
  logic [1:0] held;

  button_cmd #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_play_n(key_play_n),
    .key_stop_n(key_stop_n),
    .play      (play),
    .stop      (stop),
    .held      (held)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cyc;
    bit kind;  // 0 = play, 1 = stop
  } pulse_t;

  pulse_t expq[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     n_play_seen = 0;
  int     n_stop_seen = 0;

  // Reference model: a key level is accepted once the synchronized input
  // (raw delayed by two clocks) disagrees with it for DC samples in a row.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl[2];
  int m_run[2];
  bit m_evt[2];

  always @(posedge clk) begin
    bit raw[2];
    bit s, op, os;
    cyc++;
    raw[0] = key_play_n;
    raw[1] = key_stop_n;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b1;
        m_run[i] = 0;   m_evt[i] = 1'b0;
      end
    end else begin
      os = m_evt[1];
      op = m_evt[0] && !m_evt[1] && !m_lvl[1];
      if (op) expq.push_back('{cyc: cyc, kind: 1'b0});
      if (os) expq.push_back('{cyc: cyc, kind: 1'b1});
      for (int i = 0; i < 2; i++) begin
        s       = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
        m_evt[i] = 1'b0;
        if ((!s) != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_lvl[i] = !m_lvl[i];
            m_run[i] = 0;
            m_evt[i] = m_lvl[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ep, es;
    pulse_t p;
    ep = 1'b0;
    es = 1'b0;
    if (cyc > 0) begin
      while (expq.size() > 0 && expq[0].cyc <= cyc) begin
        p = expq.pop_front();
        if (p.kind) es = 1'b1; else ep = 1'b1;
      end
      if (ep || play) begin
        n_cmp++;
        if (play !== ep) begin
          n_bad++;
          $display("FAIL play_pulse cyc=%0d got=%b exp=%b", cyc, play, ep);
        end
      end
      if (es || stop) begin
        n_cmp++;
        if (stop !== es) begin
          n_bad++;
          $display("FAIL stop_pulse cyc=%0d got=%b exp=%b", cyc, stop, es);
        end
      end
      n_cmp++;
      if (held !== {m_lvl[1], m_lvl[0]}) begin
        n_bad++;
        $display("FAIL held cyc=%0d got=%b exp=%b%b", cyc, held, m_lvl[1], m_lvl[0]);
      end
      if (play === 1'b1) n_play_seen++;
      if (stop === 1'b1) n_stop_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  int p0, s0;

  initial begin
    // Reset release: three reset cycles, keys released
    step(3);
    chk("reset_play", int'(play), 0);
    chk("reset_stop", int'(stop), 0);
    chk("reset_held", int'(held), 3);
    rst = 1'b0;
    step(DC - 1);
    chk("rst_release_still_held", int'(held), 3);
    step(1);
    chk("rst_release_idle", int'(held), 0);
    step(4);
    chk("rst_release_no_pulse", n_play_seen + n_stop_seen, 0);

    // Clean press
    p0 = n_play_seen; s0 = n_stop_seen;
    key_play_n = 1'b0;
    step(DC + 2);
    chk("press_held_rise", int'(held[0]), 1);
    chk("press_no_early_pulse", int'(play), 0);
    step(1);
    chk("press_pulse_edge7", int'(play), 1);
    step(1);
    chk("press_pulse_one_cycle", int'(play), 0);
    step(14);
    chk("press_one_pulse", n_play_seen - p0, 1);
    chk("press_no_stop", n_stop_seen - s0, 0);

    // Bounce on release
    p0 = n_play_seen;
    for (int i = 0; i < 10; i++) begin
      key_play_n = ((i / 2) % 2 == 0);
      step(1);
    end
    step(3);
    chk("bounce_held_before", int'(held[0]), 1);
    step(1);
    chk("bounce_held_fall", int'(held[0]), 0);
    chk("bounce_no_pulse", n_play_seen - p0, 0);
    step(4);

    // Glitch on stop, then a real press
    s0 = n_stop_seen;
    key_stop_n = 1'b0; step(3);
    key_stop_n = 1'b1; step(10);
    chk("glitch_no_stop", n_stop_seen - s0, 0);
    chk("glitch_held", int'(held[1]), 0);
    key_stop_n = 1'b0; step(10);
    chk("stop_press_one", n_stop_seen - s0, 1);
    key_stop_n = 1'b1; step(DC + 4);

    // Simultaneous press: stop wins, play blocked while stop held
    p0 = n_play_seen; s0 = n_stop_seen;
    key_play_n = 1'b0; key_stop_n = 1'b0; step(DC + 6);
    chk("simul_stop", n_stop_seen - s0, 1);
    chk("simul_no_play", n_play_seen - p0, 0);
    key_play_n = 1'b1; step(DC + 4);
    key_play_n = 1'b0; step(DC + 6);
    chk("play_blocked_by_held_stop", n_play_seen - p0, 0);
    key_play_n = 1'b1; key_stop_n = 1'b1; step(DC + 4);
    key_play_n = 1'b0; step(DC + 6);
    chk("play_after_stop_release", n_play_seen - p0, 1);
    key_play_n = 1'b1; step(DC + 4);

    // Reset while a play press is mid-debounce
    p0 = n_play_seen;
    key_play_n = 1'b0; step(4);
    rst = 1'b1; step(1);
    chk("midreset_held", int'(held), 3);
    chk("midreset_play", int'(play), 0);
    rst = 1'b0; step(20);
    chk("midreset_no_play", n_play_seen - p0, 0);
    chk("midreset_still_held", int'(held[0]), 1);
    key_play_n = 1'b1; step(DC + 4);
    key_play_n = 1'b0; step(DC + 6);
    chk("midreset_repress", n_play_seen - p0, 1);
    key_play_n = 1'b1; step(DC + 4);

    // Random phase: glitchy keys and occasional resets, model-checked
    for (int it = 0; it < 300; it++) begin
      key_play_n = 1'($urandom_range(0, 1));
      key_stop_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rst = 1'b1;
      step(1);
      rst = 1'b0;
      step($urandom_range(0, 8));
    end
    key_play_n = 1'b1; key_stop_n = 1'b1;
    step(20);
    chk("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
